// File: rtl/serial_adder_ctrl_pkg.sv
// ============================================================================
// serial_adder_ctrl_pkg : shared constants and FSM encoding for serial_adder_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
// ============================================================================
// full_adder : 1-bit full adder datapath used by serial_adder_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial WIDTH-bit adder sequencer around one full_adder
// Optional subtract mode via macro SERIAL_ADDER_SUB_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_sub;
    logic             w_accept;
    logic             w_fa_s;
    logic             w_fa_co;
    logic [WIDTH-1:0] w_shift;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Result register is one bit short: the final sum bit comes straight from the adder.
    assign w_shift  = {w_fa_s, res_q};
    assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d   = w_shift[WIDTH-1:1];
                carry_d = w_fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = w_shift;
                    cout_d  = w_fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accepting from DONE gives back-to-back operation; done still pulses this cycle.
        if (w_accept) begin
            a_sh_d  = a;
            b_sh_d  = w_sub ? ~b : b;
            carry_d = w_sub ? 1'b1 : cin;
            cnt_d   = '0;
            res_d   = '0;
            state_d = S_RUN;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire
